// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter
// Owns the single register-file write port. Writeback requests from the ALU
// path (source A) and the load/multi-cycle path (source B) are each buffered in
// a small FIFO. A round-robin arbiter picks one head per cycle, and the result
// is driven to the register file from registers. busy_mask reports every
// destination that still has a write in flight so issue logic can stall.

// Small valid-bit FIFO for one writeback source. It exposes every slot so the
// parent can build the pending-write mask.
module regfile_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [4:0]                 push_rd,
  input  logic [XLEN-1:0]            push_data,
  input  logic                       pop,
  output logic                       head_valid,
  output logic [4:0]                 head_rd,
  output logic [XLEN-1:0]            head_data,
  output logic [DEPTH-1:0]           slot_valid,
  output logic [DEPTH-1:0][4:0]      slot_rd
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0][4:0]       rd_q, rd_d;
  logic [DEPTH-1:0][XLEN-1:0]  data_q, data_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic                        push_fire_s;
  logic                        pop_fire_s;

  // Ready depends only on occupancy, and is held low while reset is high.
  assign push_ready  = ~reset & ~(&vld_q);
  assign push_fire_s = push_valid & push_ready;
  assign head_valid  = vld_q[rd_ptr_q];
  assign head_rd     = rd_q[rd_ptr_q];
  assign head_data   = data_q[rd_ptr_q];
  assign pop_fire_s  = pop & head_valid;
  assign slot_valid  = vld_q;
  assign slot_rd     = rd_q;

  // Next-state for slots and pointers. Pushing and popping on the same edge is
  // safe because they can only hit the same slot when the FIFO is empty.
  always_comb begin
    vld_d    = vld_q;
    rd_d     = rd_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop_fire_s) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_fire_s) begin
      vld_d[wr_ptr_q]  = 1'b1;
      rd_d[wr_ptr_q]   = push_rd;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // FIFO state registers. Reset discards anything queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      vld_q    <= vld_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

module regfile_writeback_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            RegWrite,
  output logic [4:0]      writeReg,
  output logic [XLEN-1:0] writeData,
  output logic [31:0]     busy_mask
);

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  src_e                   last_grant_q, last_grant_d;
  logic                   reg_write_q, reg_write_d;
  logic [4:0]             write_reg_q, write_reg_d;
  logic [XLEN-1:0]        write_data_q, write_data_d;
  logic                   grant_a_s, grant_b_s;
  logic                   a_head_valid_s, b_head_valid_s;
  logic [4:0]             a_head_rd_s, b_head_rd_s;
  logic [XLEN-1:0]        a_head_data_s, b_head_data_s;
  logic [DEPTH-1:0]       a_slot_valid_s, b_slot_valid_s;
  logic [DEPTH-1:0][4:0]  a_slot_rd_s, b_slot_rd_s;
  logic [31:0]            busy_s;

  regfile_wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fifo_a (
    .clk        (clk),
    .reset      (reset),
    .push_valid (a_valid),
    .push_ready (a_ready),
    .push_rd    (a_rd),
    .push_data  (a_data),
    .pop        (grant_a_s),
    .head_valid (a_head_valid_s),
    .head_rd    (a_head_rd_s),
    .head_data  (a_head_data_s),
    .slot_valid (a_slot_valid_s),
    .slot_rd    (a_slot_rd_s)
  );

  regfile_wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fifo_b (
    .clk        (clk),
    .reset      (reset),
    .push_valid (b_valid),
    .push_ready (b_ready),
    .push_rd    (b_rd),
    .push_data  (b_data),
    .pop        (grant_b_s),
    .head_valid (b_head_valid_s),
    .head_rd    (b_head_rd_s),
    .head_data  (b_head_data_s),
    .slot_valid (b_slot_valid_s),
    .slot_rd    (b_slot_rd_s)
  );

  // Round-robin arbitration over the two FIFO heads; a tie goes to the source
  // that did not win last time.
  always_comb begin
    grant_a_s    = 1'b0;
    grant_b_s    = 1'b0;
    last_grant_d = last_grant_q;
    if (a_head_valid_s && b_head_valid_s) begin
      if (last_grant_q == SRC_B) begin
        grant_a_s    = 1'b1;
        last_grant_d = SRC_A;
      end else begin
        grant_b_s    = 1'b1;
        last_grant_d = SRC_B;
      end
    end else if (a_head_valid_s) begin
      grant_a_s    = 1'b1;
      last_grant_d = SRC_A;
    end else if (b_head_valid_s) begin
      grant_b_s    = 1'b1;
      last_grant_d = SRC_B;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Commit stage: the granted head is loaded into the write-port registers.
  // Writes to x0 are consumed without raising the enable.
  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (grant_a_s) begin
      reg_write_d  = (a_head_rd_s != 5'd0);
      write_reg_d  = a_head_rd_s;
      write_data_d = a_head_data_s;
    end else if (grant_b_s) begin
      reg_write_d  = (b_head_rd_s != 5'd0);
      write_reg_d  = b_head_rd_s;
      write_data_d = b_head_data_s;
    end else begin
      reg_write_d  = 1'b0;
    end
  end

  // Write-port and arbiter-history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= '0;
      last_grant_q <= SRC_B;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Pending-write mask: every queued entry plus the write currently on the
  // port. x0 is never reported busy since it is hard-wired.
  always_comb begin
    busy_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_s = busy_s | (32'(a_slot_valid_s[i]) << a_slot_rd_s[i]);
      busy_s = busy_s | (32'(b_slot_valid_s[i]) << b_slot_rd_s[i]);
    end
    busy_s    = busy_s | (32'(reg_write_q) << write_reg_q);
    busy_s[0] = 1'b0;
  end

  assign RegWrite  = reg_write_q;
  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;
  assign busy_mask = busy_s;

endmodule
